// File: rtl/noc_node_pkg.sv
// Shared types and helpers for the hypercube NoC router.
//   flit_t : 11-bit link flit {hop, dest, payload}
//   pkt_t  : 8-bit local packet {dest, payload}
//   route(): dimension-ordered (e-cube) output selection
package noc_pkg;

  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned NUM_OUT = 5;
  localparam int unsigned DB_PORT = 4;  // ejection output index
  localparam int unsigned DG_PORT = 4;  // injection input index

  typedef struct packed {
    logic [2:0] hop;
    logic [3:0] dest;
    logic [3:0] payload;
  } flit_t;

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] payload;
  } pkt_t;

  // Lowest differing address bit picks the link; no difference means eject.
  function automatic logic [2:0] route(input logic [3:0] dest, input logic [3:0] myIp);
    logic [3:0] diff;
    diff = dest ^ myIp;
    if (diff[0])      route = 3'd0;
    else if (diff[1]) route = 3'd1;
    else if (diff[2]) route = 3'd2;
    else if (diff[3]) route = 3'd3;
    else              route = 3'(DB_PORT);
  endfunction

endpackage

// File: rtl/noc_node_if.sv
// Channel bundle of one router node: four link inputs, four link outputs,
// the local injection channel (dg) and the local ejection channel (db).
// Every channel is a 4-phase req/ack bundled-data channel.
//   master : environment / neighbour side
//   slave  : router side
interface noc_node_if;
  import noc_pkg::*;

  logic  [3:0] in_req;
  logic  [3:0] in_ack;
  flit_t [3:0] in_data;

  logic  [3:0] out_req;
  logic  [3:0] out_ack;
  flit_t [3:0] out_data;

  logic        dg_req;
  logic        dg_ack;
  pkt_t        dg_data;

  logic        db_req;
  logic        db_ack;
  pkt_t        db_data;

  modport master (
    output in_req, in_data, out_ack, dg_req, dg_data, db_ack,
    input  in_ack, out_req, out_data, dg_ack, db_req, db_data
  );

  modport slave (
    input  in_req, in_data, out_ack, dg_req, dg_data, db_ack,
    output in_ack, out_req, out_data, dg_ack, db_req, db_data
  );

endinterface

// File: rtl/noc_node_out_port.sv
// One router output: round-robin arbiter over the buffered inputs that
// route here, an output flit register and a 4-phase sender FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   reqVec     : inputs currently requesting this output
//   candFlit   : buffered flit of every input
//   grant      : one-hot; the granted input frees its buffer on this edge
//   outReq     : channel request (registered)
//   outAck     : channel acknowledge
//   outFlit    : channel data, stable until the next grant
// IS_DB selects the ejection flavour, where the hop field is not carried.
module noc_out_port
  import noc_pkg::*;
#(
  parameter bit IS_DB = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] reqVec,
  input  flit_t             candFlit [NUM_IN],
  output logic [NUM_IN-1:0] grant,
  output logic              outReq,
  input  logic              outAck,
  output flit_t             outFlit
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic       found;
  logic [2:0] winIdx;
  logic [3:0] scan;
  flit_t      winFlit;
  flit_t      nextFlit;

  // Search starts at ptr, which always sits just after the last winner.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    scan   = '0;
    for (int unsigned off = 0; off < NUM_IN; off++) begin
      scan = {1'b0, ptr} + 4'(off);
      if (scan >= 4'(NUM_IN)) scan = scan - 4'(NUM_IN);
      if (!found && reqVec[scan[2:0]]) begin
        found  = 1'b1;
        winIdx = scan[2:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found) grant[winIdx] = 1'b1;
  end

  always_comb begin
    winFlit  = candFlit[winIdx];
    nextFlit = winFlit;
    if (IS_DB)                  nextFlit.hop = '0;
    else if (winFlit.hop != '1) nextFlit.hop = winFlit.hop + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      outReq  <= 1'b0;
      outFlit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            outFlit <= nextFlit;
            outReq  <= 1'b1;
            ptr     <= (winIdx == 3'(NUM_IN - 1)) ? '0 : winIdx + 3'd1;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (outAck) begin
            outReq <= 1'b0;
            state  <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!outAck) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/noc_node.sv
// Router for one node of a 16-node 4-D hypercube NoC.
//   clk   : single clock, all channels synchronous to it
//   rst_n : asynchronous active-low reset
//   bus   : channel bundle (links 0-3, injection dg, ejection db)
// Link k connects to node MY_IP ^ (1<<k). Each of the five inputs (links,
// dg) owns a one-flit buffer whose occupancy throttles its acknowledge.
// Each of the five outputs (links, db) arbitrates independently.
module noc_node
  import noc_pkg::*;
#(
  parameter logic [3:0] MY_IP  = 4'b0000,
  parameter int         FLIT_W = 11,
  parameter int         PKT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  noc_node_if.slave  bus
);

  logic [NUM_IN-1:0]  rxReq;
  logic [NUM_IN-1:0]  rxAck;
  logic [NUM_IN-1:0]  bufValid;
  logic [NUM_IN-1:0]  freeVec;
  logic [FLIT_W-1:0]  rxData   [NUM_IN];
  flit_t              bufFlit  [NUM_IN];
  logic [PKT_W-1:0]   dgPkt;

  logic [NUM_IN-1:0]  portReq  [NUM_OUT];
  logic [NUM_IN-1:0]  portGnt  [NUM_OUT];
  logic [NUM_OUT-1:0] txReq;
  logic [NUM_OUT-1:0] txAck;
  flit_t              txFlit   [NUM_OUT];

  // Channel mapping: links occupy indices 0-3, dg/db index 4.
  assign rxReq = {bus.dg_req, bus.in_req};
  assign txAck = {bus.db_ack, bus.out_ack};
  assign dgPkt = bus.dg_data;
  assign rxData[DG_PORT] = FLIT_W'(dgPkt);  // injected flits start at hop 0

  for (genvar k = 0; k < 4; k++) begin : gLink
    assign rxData[k]       = bus.in_data[k];
    assign bus.out_data[k] = txFlit[k];
  end

  assign bus.in_ack  = rxAck[3:0];
  assign bus.dg_ack  = rxAck[DG_PORT];
  assign bus.out_req = txReq[3:0];
  assign bus.db_req  = txReq[DB_PORT];
  assign bus.db_data = '{dest: txFlit[DB_PORT].dest, payload: txFlit[DB_PORT].payload};

  // Receive side: capture only into an empty buffer, so a waiting flit
  // keeps the next one on that input unacknowledged.
  for (genvar i = 0; i < NUM_IN; i++) begin : gRx
    logic  ackQ;
    logic  validQ;
    flit_t flitQ;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ackQ   <= 1'b0;
        validQ <= 1'b0;
        flitQ  <= '0;
      end else if (!ackQ && rxReq[i] && !validQ) begin
        flitQ  <= flit_t'(rxData[i]);
        validQ <= 1'b1;
        ackQ   <= 1'b1;
      end else begin
        if (ackQ && !rxReq[i]) ackQ <= 1'b0;
        if (freeVec[i])        validQ <= 1'b0;
      end
    end

    assign rxAck[i]    = ackQ;
    assign bufValid[i] = validQ;
    assign bufFlit[i]  = flitQ;
  end

  always_comb begin
    for (int unsigned o = 0; o < NUM_OUT; o++) portReq[o] = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bufValid[i]) portReq[route(bufFlit[i].dest, MY_IP)][i] = 1'b1;
    end
  end

  // Every input routes to exactly one output, so at most one grant hits it.
  always_comb begin
    freeVec = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++) freeVec = freeVec | portGnt[o];
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : gOut
    noc_out_port #(
      .IS_DB(o == DB_PORT)
    ) uPort (
      .clk      (clk),
      .rst_n    (rst_n),
      .reqVec   (portReq[o]),
      .candFlit (bufFlit),
      .grant    (portGnt[o]),
      .outReq   (txReq[o]),
      .outAck   (txAck[o]),
      .outFlit  (txFlit[o])
    );
  end

endmodule

// File: tb/tb_noc_node.sv
// Scoreboard bench for noc_node: two routers (MY_IP 0 and 3) driven by
// directed stimulus; expected outputs are queued per output channel and a
// negedge monitor acts as the 4-phase sink, popping and comparing.
module tb_noc_node;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  noc_node_if if0 ();
  noc_node_if if3 ();

  noc_node #(.MY_IP(4'd0), .FLIT_W(11), .PKT_W(8)) dut0 (
    .clk(clk), .rst_n(rstN), .bus(if0.slave)
  );
  noc_node #(.MY_IP(4'd3), .FLIT_W(11), .PKT_W(8)) dut3 (
    .clk(clk), .rst_n(rstN), .bus(if3.slave)
  );

  // Index 0 = dut0, index 1 = dut3; channel 4 is dg (source) / db (sink).
  logic [4:0]  srcReq  [2];
  logic [10:0] srcData [2][5];
  logic [4:0]  srcAck  [2];
  logic [4:0]  snkReq  [2];
  logic [10:0] snkData [2][5];
  logic [4:0]  snkAck  [2] = '{default: '0};
  logic [4:0]  snkHold [2] = '{default: '0};

  logic [10:0] expQ [10][$];
  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;

  assign if0.in_req  = srcReq[0][3:0];
  assign if0.dg_req  = srcReq[0][4];
  assign if0.dg_data = srcData[0][4][7:0];
  assign if0.out_ack = snkAck[0][3:0];
  assign if0.db_ack  = snkAck[0][4];
  assign srcAck[0]   = {if0.dg_ack, if0.in_ack};
  assign snkReq[0]   = {if0.db_req, if0.out_req};
  assign snkData[0][4] = {3'b000, if0.db_data};

  assign if3.in_req  = srcReq[1][3:0];
  assign if3.dg_req  = srcReq[1][4];
  assign if3.dg_data = srcData[1][4][7:0];
  assign if3.out_ack = snkAck[1][3:0];
  assign if3.db_ack  = snkAck[1][4];
  assign srcAck[1]   = {if3.dg_ack, if3.in_ack};
  assign snkReq[1]   = {if3.db_req, if3.out_req};
  assign snkData[1][4] = {3'b000, if3.db_data};

  for (genvar k = 0; k < 4; k++) begin : gMap
    assign if0.in_data[k] = srcData[0][k];
    assign if3.in_data[k] = srcData[1][k];
    assign snkData[0][k]  = if0.out_data[k];
    assign snkData[1][k]  = if3.out_data[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Sink monitor: compare on each new request, then complete the handshake.
  int unsigned ch;
  logic [10:0] expv;
  always @(negedge clk) begin
    for (int unsigned d = 0; d < 2; d++) begin
      for (int unsigned c = 0; c < 5; c++) begin
        ch = d * 5 + c;
        if (!rstN) begin
          snkAck[d][c] = 1'b0;
        end else if (snkAck[d][c]) begin
          if (!snkReq[d][c]) snkAck[d][c] = 1'b0;
        end else if (snkReq[d][c] && !snkHold[d][c]) begin
          if (expQ[ch].size() == 0) begin
            totalCnt++;
            $display("FAIL d%0d out%0d unexpected req: got data %0h, expected no request",
                     d, c, snkData[d][c]);
          end else begin
            expv = expQ[ch].pop_front();
            check($sformatf("d%0d out%0d data", d, c), 32'(snkData[d][c]), 32'(expv));
          end
          snkAck[d][c] = 1'b1;
        end
      end
    end
  end

  function automatic int unsigned pending();
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 10; i++) s += expQ[i].size();
    for (int unsigned d = 0; d < 2; d++) s += $countones(snkReq[d]) + $countones(snkAck[d]);
    return s;
  endfunction

  task automatic sendIn(input int unsigned d, input int unsigned p, input logic [10:0] f);
    int unsigned n;
    srcData[d][p] = f;
    srcReq[d][p]  = 1'b1;
    n = 0;
    while (!srcAck[d][p] && n < 40) begin @(posedge clk); #1; n++; end
    check($sformatf("d%0d in%0d ack rise", d, p), 32'(srcAck[d][p]), 32'd1);
    srcReq[d][p] = 1'b0;
    n = 0;
    while (srcAck[d][p] && n < 40) begin @(posedge clk); #1; n++; end
    check($sformatf("d%0d in%0d ack fall", d, p), 32'(srcAck[d][p]), 32'd0);
  endtask

  task automatic idleCheck(input string tag);
    for (int unsigned d = 0; d < 2; d++)
      check($sformatf("%s idle d%0d req/ack", tag, d), 32'({snkReq[d], srcAck[d]}), 32'd0);
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    n = 0;
    while (pending() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, " drain"}, pending(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    idleCheck(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "time limit");
  end

  initial begin
    rstN = 1'b0;
    for (int unsigned d = 0; d < 2; d++) begin
      srcReq[d] = '0;
      for (int unsigned c = 0; c < 5; c++) srcData[d][c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d req/ack", d), 32'({snkReq[d], srcAck[d]}), 32'd0);
      for (int unsigned c = 0; c < 5; c++)
        check($sformatf("reset d%0d out%0d data", d, c), 32'(snkData[d][c]), 32'd0);
    end
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Inject 0x11 at node 0: dest 1 leaves on link 0 with hop 1, 2-clk latency.
    expQ[0].push_back(11'h111);
    srcData[0][4] = 11'h011;
    srcReq[0][4]  = 1'b1;
    @(posedge clk);
    #1;
    check("dg ack at capture", 32'(srcAck[0][4]), 32'd1);
    check("out0 req after 1 clk", 32'(snkReq[0][0]), 32'd0);
    srcReq[0][4] = 1'b0;
    @(posedge clk);
    #1;
    check("out0 req after 2 clk", 32'(snkReq[0][0]), 32'd1);
    drain("inject 11");

    // Local destination ejects to db.
    expQ[4].push_back(11'h00F);
    sendIn(0, 4, 11'h00F);
    drain("inject 0F");

    // Dest 3 from node 0: lowest differing bit is 0.
    expQ[0].push_back(11'h137);
    sendIn(0, 4, 11'h037);
    drain("inject 37");

    // Node 3: own address ejects; dest C differs in all bits -> link 0, hop saturated.
    expQ[9].push_back(11'h037);
    sendIn(1, 1, 11'h237);
    expQ[5].push_back(11'h7C5);
    sendIn(1, 2, 11'h7C5);
    drain("node3");

    // Link-2 winner on output 0 leaves the arbiter pointer at input 3.
    expQ[0].push_back(11'h115);
    sendIn(0, 2, 11'h015);
    drain("rr setup");

    // Same-cycle dg and link 1 for output 0: dg served first, link 1 waits;
    // the next link-1 flit stays unacknowledged while its buffer is occupied.
    expQ[0].push_back(11'h11A);
    expQ[0].push_back(11'h213);
    expQ[4].push_back(11'h005);
    fork
      sendIn(0, 4, 11'h01A);
      begin
        sendIn(0, 1, 11'h113);
        srcData[0][1] = 11'h005;
        srcReq[0][1]  = 1'b1;
        @(posedge clk);
        #1;
        check("link1 held off while buffer full", 32'(srcAck[0][1]), 32'd0);
        sendIn(0, 1, 11'h005);
      end
    join
    drain("contention");

    // Reset in the middle of traffic.
    snkHold[0][0] = 1'b1;
    sendIn(0, 2, 11'h013);
    srcData[0][2] = 11'h014;
    srcReq[0][2]  = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset out0 req", 32'(snkReq[0][0]), 32'd1);
    check("pre-reset in2 ack", 32'(srcAck[0][2]), 32'd1);
    #3;
    rstN = 1'b0;
    #1;
    check("reset drops out0 req", 32'(snkReq[0][0]), 32'd0);
    check("reset drops in2 ack", 32'(srcAck[0][2]), 32'd0);
    srcReq[0][2]  = 1'b0;
    snkHold[0][0] = 1'b0;
    @(posedge clk);
    #2;
    rstN = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    idleCheck("post-reset");
    check("post-reset pending", pending(), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
